// File: rtl/alu_op_sequencer_pkg.sv
// Shared constants for the ALU command sequencer: opcodes, ALU controls,
// operand-B mux selects, FSM encoding and the decoder payload.
package alu_op_sequencer_pkg;

  localparam int unsigned XLEN_DEF    = 32;
  localparam int unsigned RADDR_W_DEF = 5;
  localparam int unsigned OP_W        = 3;
  localparam int unsigned ALU_CTRL_W  = 4;
  localparam int unsigned MUX_W       = 2;
  localparam int unsigned ST_W        = 2;

  localparam logic [OP_W-1:0] OP_ADD  = 3'd0;
  localparam logic [OP_W-1:0] OP_SUB  = 3'd1;
  localparam logic [OP_W-1:0] OP_AND  = 3'd2;
  localparam logic [OP_W-1:0] OP_OR   = 3'd3;
  localparam logic [OP_W-1:0] OP_SLT  = 3'd4;
  localparam logic [OP_W-1:0] OP_ADDI = 3'd5;
  localparam logic [OP_W-1:0] OP_LI   = 3'd6;
  localparam logic [OP_W-1:0] OP_RD   = 3'd7;

  localparam logic [ALU_CTRL_W-1:0] ALU_AND = 4'd0;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 4'd1;
  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 4'd2;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 4'd6;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT = 4'd7;

  localparam logic [MUX_W-1:0] MUX_RV2 = 2'd0;
  localparam logic [MUX_W-1:0] MUX_IMM = 2'd1;

  localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [ST_W-1:0] ST_EXEC  = 2'd1;
  localparam logic [ST_W-1:0] ST_WRITE = 2'd2;
  localparam logic [ST_W-1:0] ST_RESP  = 2'd3;

  // bypass: result is the immediate; no_write: result is rv1 and no write-back
  typedef struct packed {
    logic [ALU_CTRL_W-1:0] alu_control;
    logic [MUX_W-1:0]      alu_mux;
    logic                  bypass;
    logic                  no_write;
  } dec_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode decoder: maps a command opcode to ALU control,
// operand-B select and the LI/RD special-case flags.
module alu_op_decode
  import alu_op_sequencer_pkg::*;
(
  input  logic [OP_W-1:0] op,
  output dec_t            dec_c
);

  always_comb begin
    dec_c = '{alu_control: ALU_ADD, alu_mux: MUX_RV2, bypass: 1'b0, no_write: 1'b0};
    case (op)
      OP_ADD:  dec_c.alu_control = ALU_ADD;
      OP_SUB:  dec_c.alu_control = ALU_SUB;
      OP_AND:  dec_c.alu_control = ALU_AND;
      OP_OR:   dec_c.alu_control = ALU_OR;
      OP_SLT:  dec_c.alu_control = ALU_SLT;
      OP_ADDI: begin
        dec_c.alu_control = ALU_ADD;
        dec_c.alu_mux     = MUX_IMM;
      end
      OP_LI:   dec_c.bypass   = 1'b1;
      OP_RD:   dec_c.no_write = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Command sequencer for the register-file/ALU datapath: accepts a command,
// runs read/execute/write-back, then holds the response until taken.
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int unsigned XLEN    = XLEN_DEF,
  parameter int unsigned RADDR_W = RADDR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [OP_W-1:0]       cmd_op,
  input  logic [RADDR_W-1:0]    cmd_rs1,
  input  logic [RADDR_W-1:0]    cmd_rs2,
  input  logic [RADDR_W-1:0]    cmd_rd,
  input  logic [XLEN-1:0]       cmd_imm,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [XLEN-1:0]       rsp_result,
  output logic                  rsp_zero,
  output logic [RADDR_W-1:0]    rf_rs1,
  output logic [RADDR_W-1:0]    rf_rs2,
  output logic [RADDR_W-1:0]    rf_rd,
  output logic                  rf_regWrite,
  output logic [XLEN-1:0]       rf_data,
  input  logic [XLEN-1:0]       rf_rv1,
  input  logic [XLEN-1:0]       rf_rv2,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic [MUX_W-1:0]      alu_mux,
  output logic [XLEN-1:0]       alu_imm,
  input  logic [XLEN-1:0]       alu_result,
  input  logic                  alu_zero
);

  dec_t dec_c;

  logic [ST_W-1:0]       state_q,       state_d;
  logic                  cmd_ready_q,   cmd_ready_d;
  logic                  rsp_valid_q,   rsp_valid_d;
  logic [RADDR_W-1:0]    rd_q,          rd_d;
  logic                  bypass_q,      bypass_d;
  logic                  no_write_q,    no_write_d;
  logic [XLEN-1:0]       result_q,      result_d;
  logic                  zero_q,        zero_d;
  logic [RADDR_W-1:0]    rf_rs1_q,      rf_rs1_d;
  logic [RADDR_W-1:0]    rf_rs2_q,      rf_rs2_d;
  logic [RADDR_W-1:0]    rf_rd_q,       rf_rd_d;
  logic                  rf_regwrite_q, rf_regwrite_d;
  logic [XLEN-1:0]       rf_data_q,     rf_data_d;
  logic [ALU_CTRL_W-1:0] alu_control_q, alu_control_d;
  logic [MUX_W-1:0]      alu_mux_q,     alu_mux_d;
  logic [XLEN-1:0]       alu_imm_q,     alu_imm_d;

  // rv2 only feeds the external ALU; the sequencer never looks at it
  logic rv2_unused;
  assign rv2_unused = ^rf_rv2;

  alu_op_decode u_decode (
    .op    (cmd_op),
    .dec_c (dec_c)
  );

  // Next-state and next-output logic; every output is registered from its _d
  always_comb begin
    state_d       = state_q;
    rd_d          = rd_q;
    bypass_d      = bypass_q;
    no_write_d    = no_write_q;
    result_d      = result_q;
    zero_d        = zero_q;
    rf_rs1_d      = rf_rs1_q;
    rf_rs2_d      = rf_rs2_q;
    rf_rd_d       = rf_rd_q;
    rf_regwrite_d = 1'b0;
    rf_data_d     = rf_data_q;
    alu_control_d = alu_control_q;
    alu_mux_d     = alu_mux_q;
    alu_imm_d     = alu_imm_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_d       = ST_EXEC;
          rf_rs1_d      = cmd_rs1;
          rf_rs2_d      = cmd_rs2;
          rd_d          = cmd_rd;
          alu_imm_d     = cmd_imm;
          alu_control_d = dec_c.alu_control;
          alu_mux_d     = dec_c.alu_mux;
          bypass_d      = dec_c.bypass;
          no_write_d    = dec_c.no_write;
        end
      end
      ST_EXEC: begin
        if (bypass_q) begin
          result_d = alu_imm_q;
          zero_d   = (alu_imm_q == '0);
        end else if (no_write_q) begin
          result_d = rf_rv1;
          zero_d   = (rf_rv1 == '0);
        end else begin
          result_d = alu_result;
          zero_d   = alu_zero;
        end
        if (no_write_q) begin
          state_d = ST_RESP;
        end else begin
          // x0 is hardwired zero, so a write to it is suppressed
          state_d       = ST_WRITE;
          rf_rd_d       = rd_q;
          rf_data_d     = result_d;
          rf_regwrite_d = (rd_q != '0);
        end
      end
      ST_WRITE: state_d = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    cmd_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cmd_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rd_q          <= '0;
      bypass_q      <= 1'b0;
      no_write_q    <= 1'b0;
      result_q      <= '0;
      zero_q        <= 1'b0;
      rf_rs1_q      <= '0;
      rf_rs2_q      <= '0;
      rf_rd_q       <= '0;
      rf_regwrite_q <= 1'b0;
      rf_data_q     <= '0;
      alu_control_q <= '0;
      alu_mux_q     <= '0;
      alu_imm_q     <= '0;
    end else begin
      state_q       <= state_d;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rd_q          <= rd_d;
      bypass_q      <= bypass_d;
      no_write_q    <= no_write_d;
      result_q      <= result_d;
      zero_q        <= zero_d;
      rf_rs1_q      <= rf_rs1_d;
      rf_rs2_q      <= rf_rs2_d;
      rf_rd_q       <= rf_rd_d;
      rf_regwrite_q <= rf_regwrite_d;
      rf_data_q     <= rf_data_d;
      alu_control_q <= alu_control_d;
      alu_mux_q     <= alu_mux_d;
      alu_imm_q     <= alu_imm_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_result  = result_q;
  assign rsp_zero    = zero_q;
  assign rf_rs1      = rf_rs1_q;
  assign rf_rs2      = rf_rs2_q;
  assign rf_rd       = rf_rd_q;
  assign rf_regWrite = rf_regwrite_q;
  assign rf_data     = rf_data_q;
  assign alu_control = alu_control_q;
  assign alu_mux     = alu_mux_q;
  assign alu_imm     = alu_imm_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: behavioural register file and ALU around the
// DUT, with a queue of expected responses built from an opcode-level model.
module tb_alu_op_sequencer;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned RADDR_W = 5;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [2:0]         cmd_op;
  logic [RADDR_W-1:0] cmd_rs1, cmd_rs2, cmd_rd;
  logic [XLEN-1:0]    cmd_imm;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [XLEN-1:0]    rsp_result;
  logic               rsp_zero;
  logic [RADDR_W-1:0] rf_rs1, rf_rs2, rf_rd;
  logic               rf_regWrite;
  logic [XLEN-1:0]    rf_data, rf_rv1, rf_rv2;
  logic [3:0]         alu_control;
  logic [1:0]         alu_mux;
  logic [XLEN-1:0]    alu_imm, alu_result, alu_b;
  logic               alu_zero;

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic            zero;
  } exp_t;

  exp_t            sb[$];
  logic [XLEN-1:0] exp_regs [32];
  logic [XLEN-1:0] rf_mem   [32];
  int              n_checks = 0;
  int              n_fail   = 0;
  int              wr_count = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.XLEN(XLEN), .RADDR_W(RADDR_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_rs1     (cmd_rs1),
    .cmd_rs2     (cmd_rs2),
    .cmd_rd      (cmd_rd),
    .cmd_imm     (cmd_imm),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_result  (rsp_result),
    .rsp_zero    (rsp_zero),
    .rf_rs1      (rf_rs1),
    .rf_rs2      (rf_rs2),
    .rf_rd       (rf_rd),
    .rf_regWrite (rf_regWrite),
    .rf_data     (rf_data),
    .rf_rv1      (rf_rv1),
    .rf_rv2      (rf_rv2),
    .alu_control (alu_control),
    .alu_mux     (alu_mux),
    .alu_imm     (alu_imm),
    .alu_result  (alu_result),
    .alu_zero    (alu_zero)
  );

  // Datapath models: register file with x0 tied low, and the ALU
  assign rf_rv1 = (rf_rs1 == 5'd0) ? 32'd0 : rf_mem[rf_rs1];
  assign rf_rv2 = (rf_rs2 == 5'd0) ? 32'd0 : rf_mem[rf_rs2];

  always @(posedge clk) begin
    if (rf_regWrite && rf_rd != 5'd0) rf_mem[rf_rd] <= rf_data;
    if (rf_regWrite) wr_count <= wr_count + 1;
  end

  always_comb begin
    alu_b = (alu_mux == 2'd1) ? alu_imm : rf_rv2;
    case (alu_control)
      4'd0:    alu_result = rf_rv1 & alu_b;
      4'd1:    alu_result = rf_rv1 | alu_b;
      4'd2:    alu_result = rf_rv1 + alu_b;
      4'd6:    alu_result = rf_rv1 - alu_b;
      4'd7:    alu_result = ($signed(rf_rv1) < $signed(alu_b)) ? 32'd1 : 32'd0;
      default: alu_result = 32'hDEAD_BEEF;
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  // Opcode-level reference: expected response and architectural register update
  function automatic void push_expected(input logic [2:0] op, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [4:0] rd,
                                        input logic [31:0] imm);
    logic [31:0] a, b, r;
    a = exp_regs[rs1];
    b = exp_regs[rs2];
    case (op)
      3'd0:    r = a + b;
      3'd1:    r = a - b;
      3'd2:    r = a & b;
      3'd3:    r = a | b;
      3'd4:    r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd5:    r = a + imm;
      3'd6:    r = imm;
      default: r = a;
    endcase
    if (op != 3'd7 && rd != 5'd0) exp_regs[rd] = r;
    sb.push_back('{result: r, zero: (r == 32'd0)});
  endfunction

  task automatic send_cmd(input logic [2:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic [31:0] imm);
    int t = 0;
    while (cmd_ready !== 1'b1 && t < 20) begin
      @(posedge clk); #1; t++;
    end
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL send_timeout: cmd_ready=%b required 1", cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_op = op; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_rd = rd; cmd_imm = imm;
    push_expected(op, rs1, rs2, rd, imm);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output logic [31:0] res, output logic z, output int cyc);
    cyc = 0;
    while (rsp_valid !== 1'b1 && cyc < 20) begin
      @(posedge clk); #1; cyc++;
    end
    n_checks++;
    if (rsp_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rsp_timeout: rsp_valid=%b required 1", rsp_valid);
    end
    res = rsp_result;
    z   = rsp_zero;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_op = '0; cmd_rs1 = '0; cmd_rs2 = '0; cmd_rd = '0; cmd_imm = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b required 0", rsp_valid); end
    n_checks++;
    if (rf_regWrite !== 1'b0) begin n_fail++; $display("FAIL reset_regwrite: got %b required 0", rf_regWrite); end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b required 1", cmd_ready); end
    n_checks++;
    if (rsp_result !== 32'd0) begin n_fail++; $display("FAIL reset_rsp_result: got %h required 0", rsp_result); end
    n_checks++;
    if (alu_imm !== 32'd0 || alu_control !== 4'd0 || rf_rd !== 5'd0 || rf_data !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: alu_imm=%h alu_control=%0d rf_rd=%0d rf_data=%h required all 0",
               alu_imm, alu_control, rf_rd, rf_data);
    end
  endtask

  task automatic test_li();
    logic [31:0] res; logic z; int cyc; exp_t e; int wc0;
    wc0 = wr_count;
    send_cmd(3'd6, 5'd0, 5'd0, 5'd4, 32'd4323);
    n_checks++;
    if (rf_regWrite !== 1'b0) begin n_fail++; $display("FAIL li_exec_regwrite: got %b required 0", rf_regWrite); end
    @(posedge clk); #1;
    n_checks++;
    if (rf_regWrite !== 1'b1 || rf_rd !== 5'd4 || rf_data !== 32'h0000_10E3) begin
      n_fail++;
      $display("FAIL li_write: regWrite=%b rd=%0d data=%h required 1 4 000010e3", rf_regWrite, rf_rd, rf_data);
    end
    wait_rsp(res, z, cyc);
    e = sb.pop_front();
    n_checks++;
    if (res !== e.result || z !== e.zero) begin
      n_fail++; $display("FAIL li_rsp: got %h/%b required %h/%b", res, z, e.result, e.zero);
    end
    n_checks++;
    if (wr_count - wc0 !== 1) begin n_fail++; $display("FAIL li_pulses: got %0d required 1", wr_count - wc0); end
  endtask

  task automatic test_add();
    logic [31:0] res; logic z; int cyc; exp_t e;
    send_cmd(3'd0, 5'd3, 5'd4, 5'd5, 32'd0);
    n_checks++;
    if (alu_control !== 4'd2 || alu_mux !== 2'd0 || rf_rs1 !== 5'd3 || rf_rs2 !== 5'd4) begin
      n_fail++;
      $display("FAIL add_exec: ctrl=%0d mux=%0d rs1=%0d rs2=%0d required 2 0 3 4", alu_control, alu_mux, rf_rs1, rf_rs2);
    end
    wait_rsp(res, z, cyc);
    n_checks++;
    if (cyc !== 2) begin n_fail++; $display("FAIL add_latency: got %0d more cycles required 2", cyc); end
    e = sb.pop_front();
    n_checks++;
    if (res !== e.result || z !== e.zero) begin
      n_fail++; $display("FAIL add_rsp: got %h/%b required %h/%b", res, z, e.result, e.zero);
    end
    n_checks++;
    if (rf_mem[5] !== 32'h0000_10E3) begin n_fail++; $display("FAIL add_x5: got %h required 000010e3", rf_mem[5]); end
  endtask

  task automatic test_sub_slt();
    logic [31:0] res; logic z; int cyc; exp_t e;
    send_cmd(3'd1, 5'd4, 5'd4, 5'd6, 32'd0);
    n_checks++;
    if (alu_control !== 4'd6) begin n_fail++; $display("FAIL sub_ctrl: got %0d required 6", alu_control); end
    wait_rsp(res, z, cyc);
    e = sb.pop_front();
    n_checks++;
    if (res !== e.result || z !== e.zero) begin
      n_fail++; $display("FAIL sub_rsp: got %h/%b required %h/%b", res, z, e.result, e.zero);
    end
    send_cmd(3'd4, 5'd3, 5'd4, 5'd7, 32'd0);
    n_checks++;
    if (alu_control !== 4'd7) begin n_fail++; $display("FAIL slt_ctrl: got %0d required 7", alu_control); end
    wait_rsp(res, z, cyc);
    e = sb.pop_front();
    n_checks++;
    if (res !== e.result || z !== e.zero) begin
      n_fail++; $display("FAIL slt_rsp: got %h/%b required %h/%b", res, z, e.result, e.zero);
    end
    n_checks++;
    if (rf_mem[7] !== 32'd1) begin n_fail++; $display("FAIL slt_x7: got %h required 1", rf_mem[7]); end
  endtask

  task automatic test_addi_li0();
    logic [31:0] res; logic z; int cyc; exp_t e; int wc0;
    send_cmd(3'd5, 5'd4, 5'd0, 5'd8, 32'hFFFF_FFFF);
    n_checks++;
    if (alu_mux !== 2'd1 || alu_imm !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL addi_exec: mux=%0d imm=%h required 1 ffffffff", alu_mux, alu_imm);
    end
    wait_rsp(res, z, cyc);
    e = sb.pop_front();
    n_checks++;
    if (res !== e.result || z !== e.zero) begin
      n_fail++; $display("FAIL addi_rsp: got %h/%b required %h/%b", res, z, e.result, e.zero);
    end
    wc0 = wr_count;
    send_cmd(3'd6, 5'd0, 5'd0, 5'd0, 32'd5);
    @(posedge clk); #1;
    n_checks++;
    if (rf_regWrite !== 1'b0) begin n_fail++; $display("FAIL li0_regwrite: got %b required 0", rf_regWrite); end
    wait_rsp(res, z, cyc);
    e = sb.pop_front();
    n_checks++;
    if (res !== e.result || z !== e.zero) begin
      n_fail++; $display("FAIL li0_rsp: got %h/%b required %h/%b", res, z, e.result, e.zero);
    end
    n_checks++;
    if (wr_count - wc0 !== 0) begin n_fail++; $display("FAIL li0_pulses: got %0d required 0", wr_count - wc0); end
  endtask

  task automatic test_rd();
    logic [31:0] res; logic z; int cyc; exp_t e; int wc0;
    wc0 = wr_count;
    send_cmd(3'd7, 5'd5, 5'd0, 5'd9, 32'd0);
    wait_rsp(res, z, cyc);
    n_checks++;
    if (cyc !== 1) begin n_fail++; $display("FAIL rd_latency: got %0d more cycles required 1", cyc); end
    e = sb.pop_front();
    n_checks++;
    if (res !== e.result || z !== e.zero) begin
      n_fail++; $display("FAIL rd_rsp: got %h/%b required %h/%b", res, z, e.result, e.zero);
    end
    n_checks++;
    if (wr_count - wc0 !== 0) begin n_fail++; $display("FAIL rd_pulses: got %0d required 0", wr_count - wc0); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] res; logic z; int cyc; exp_t e;
    send_cmd(3'd0, 5'd4, 5'd4, 5'd9, 32'd0);
    cyc = 0;
    while (rsp_valid !== 1'b1 && cyc < 20) begin
      @(posedge clk); #1; cyc++;
    end
    cmd_valid = 1'b1;
    cmd_op = 3'd3; cmd_rs1 = 5'd9; cmd_rs2 = 5'd4; cmd_rd = 5'd10; cmd_imm = 32'd0;
    push_expected(3'd3, 5'd9, 5'd4, 5'd10, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (cmd_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_result !== sb[0].result) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: cmd_ready=%b rsp_valid=%b result=%h required 0 1 %h",
                 i, cmd_ready, rsp_valid, rsp_result, sb[0].result);
      end
    end
    res = rsp_result; z = rsp_zero;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    e = sb.pop_front();
    n_checks++;
    if (res !== e.result || z !== e.zero) begin
      n_fail++; $display("FAIL bp_first_rsp: got %h/%b required %h/%b", res, z, e.result, e.zero);
    end
    n_checks++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after: got %b required 1", cmd_ready); end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    n_checks++;
    if (cmd_ready !== 1'b0 || alu_control !== 4'd1) begin
      n_fail++; $display("FAIL bp_second_accept: cmd_ready=%b ctrl=%0d required 0 1", cmd_ready, alu_control);
    end
    wait_rsp(res, z, cyc);
    e = sb.pop_front();
    n_checks++;
    if (res !== e.result || z !== e.zero) begin
      n_fail++; $display("FAIL bp_second_rsp: got %h/%b required %h/%b", res, z, e.result, e.zero);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] res; logic z; int cyc; exp_t e; int wc0;
    wc0 = wr_count;
    send_cmd(3'd0, 5'd4, 5'd4, 5'd11, 32'd0);
    @(posedge clk); #1;
    n_checks++;
    if (rf_regWrite !== 1'b1) begin n_fail++; $display("FAIL rm_in_write: got %b required 1", rf_regWrite); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (rf_regWrite !== 1'b0 || rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL rm_async: regWrite=%b rsp_valid=%b required 0 0", rf_regWrite, rsp_valid);
    end
    void'(sb.pop_back());
    exp_regs[11] = 32'd0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    n_checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL rm_release: cmd_ready=%b rsp_valid=%b required 1 0", cmd_ready, rsp_valid);
    end
    send_cmd(3'd7, 5'd11, 5'd0, 5'd0, 32'd0);
    wait_rsp(res, z, cyc);
    e = sb.pop_front();
    n_checks++;
    if (res !== e.result || z !== e.zero) begin
      n_fail++; $display("FAIL rm_readback: got %h/%b required %h/%b", res, z, e.result, e.zero);
    end
    n_checks++;
    if (wr_count - wc0 !== 0 || rf_mem[11] !== 32'd0) begin
      n_fail++; $display("FAIL rm_no_write: pulses=%0d x11=%h required 0 0", wr_count - wc0, rf_mem[11]);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      rf_mem[i]   = '0;
      exp_regs[i] = '0;
    end
    test_reset();
    test_li();
    test_add();
    test_sub_slt();
    test_addi_li0();
    test_rd();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Hardware command sequencer that drives the register-file/ALU datapath. It performs the read-operands, execute, write-back sequence autonomously for each accepted command. Commands arrive on a valid/ready channel from an upstream controller. Results return on a valid/ready response channel.

Parameters:
XLEN, 32, datapath word width
RADDR_W, 5, register address width (32 registers, x0 hardwired zero)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous assert, active-low
cmd_valid  in  1  command present
cmd_ready  out  1  sequencer can accept a command
cmd_op  in  3  operation code (see Behaviour)
cmd_rs1  in  RADDR_W  source register 1
cmd_rs2  in  RADDR_W  source register 2
cmd_rd  in  RADDR_W  destination register
cmd_imm  in  XLEN  immediate
rsp_valid  out  1  response present
rsp_ready  in  1  upstream accepts response
rsp_result  out  XLEN  value written, or value read
rsp_zero  out  1  ALU zero flag for the command
rf_rs1  out  RADDR_W  register file read address 1
rf_rs2  out  RADDR_W  register file read address 2
rf_rd  out  RADDR_W  register file write address
rf_regWrite  out  1  register file write enable
rf_data  out  XLEN  register file write data
rf_rv1  in  XLEN  read value 1 (combinational read)
rf_rv2  in  XLEN  read value 2 (combinational read)
alu_control  out  4  ALU function select
alu_mux  out  2  operand B select: 0 = rv2, 1 = immGen
alu_imm  out  XLEN  immediate to datapath immGen
alu_result  in  XLEN  ALU result (combinational)
alu_zero  in  1  ALU zero flag

Behaviour:
- Opcodes and ALU control values:
  - 0 ADD, control 2
  - 1 SUB, control 6
  - 2 AND, control 0
  - 3 OR, control 1
  - 4 SLT, control 7
  - 5 ADDI, control 2 with mux 1
  - 6 LI: rd = imm, ALU bypassed
  - 7 RD: no write; rsp_result = rv1
- FSM states: IDLE, EXEC, WRITE, RESP.
  - IDLE: cmd_ready = 1. On cmd_valid, latch all cmd_* fields and go to EXEC.
  - EXEC (1 cycle): drive rf_rs1, rf_rs2, alu_control, alu_mux and alu_imm from the latched command. At the clock edge, register alu_result and alu_zero. LI registers imm with zero = (imm == 0). RD registers rv1 with zero = (rv1 == 0). Go to WRITE, or go to RESP if op = RD.
  - WRITE (1 cycle): rf_regWrite = 1, rf_rd = latched rd, rf_data = registered result. Go to RESP.
  - RESP: rsp_valid = 1 and response outputs held stable. On rsp_ready, go to IDLE.
- Latency: accept at cycle N. Write strobe in cycle N+2. rsp_valid from cycle N+3 (N+2 for RD). Best-case throughput is one command per 4 cycles.
- cmd_ready = 0 outside IDLE. No command is accepted while a response is pending.
- rd = 0: rf_regWrite stays 0 in WRITE. The response is still issued with the computed result.
- rf_regWrite is asserted only in WRITE and never in any other state.
- Outside EXEC the address, control and immediate outputs hold their last values. rf_data is valid only in WRITE.
- Arithmetic is modulo 2^XLEN. SLT is signed and returns 1 or 0.
- Reset, including mid-operation:
  - State goes to IDLE immediately.
  - cmd_ready = 1 while rst_n = 1 and state is IDLE.
  - rsp_valid = 0, rf_regWrite = 0.
  - All latched fields, rf_* address/data outputs, alu_* outputs and rsp_* data reset to 0.
  - An in-flight write is aborted and its response is dropped.

Decomposition:
- Shared package holds:
  - opcode localparams (OP_ADD … OP_RD)
  - ALU control constants (ALU_AND = 0, ALU_OR = 1, ALU_ADD = 2, ALU_SUB = 6, ALU_SLT = 7)
  - mux constants (MUX_RV2 = 0, MUX_IMM = 1)
  - FSM state encoding
- Natural sub-module: alu_op_decode. It is combinational and maps cmd_op to {alu_control, alu_mux, bypass, no_write}. All state stays in the sequencer.

Test Plan:
- LI x4, imm = 4323 → rf_regWrite pulses once with rf_rd = 4, rf_data = 0x000010E3; rsp_result = 0x000010E3, rsp_zero = 0.
- ADD x5 = x3(0) + x4(4323) → alu_control = 2, alu_mux = 0 in EXEC; x5 written 0x000010E3; rsp_zero = 0; rsp_valid 3 cycles after accept.
- SUB x6 = x4 − x4 → alu_control = 6; x6 = 0; rsp_zero = 1. Then SLT x7 = x3(0) < x4 → 1.
- ADDI x8 = x4 + 0xFFFFFFFF → alu_mux = 1, alu_imm = 0xFFFFFFFF; result 0x000010E2. LI x0, 5 → no rf_regWrite pulse, rsp_result = 5.
- Back-pressure: hold rsp_ready = 0 for 5 cycles with a second cmd_valid pending → cmd_ready stays 0, response stable, second command accepted the cycle after the handshake.
- Assert rst_n = 0 during WRITE → rf_regWrite falls without waiting for a clock edge, rsp_valid = 0; after release, cmd_ready = 1 and the target register is unchanged on read-back via RD.
